// File: rtl/sq_pkg.sv
// Shared types and default widths for the odd-sum squarer.
package sq_pkg;
    localparam int SQ_IN_W  = 4;
    localparam int SQ_OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sq_state_t;
endpackage

// File: rtl/sq_odd_sum_if.sv
// Request/response bundle for sq_odd_sum; abort exists only with SQ_ABORT_EN.
interface sq_odd_sum_if import sq_pkg::*; #(
    parameter int IN_W  = SQ_IN_W,
    parameter int OUT_W = SQ_OUT_W
);
    // Handshake: a request is taken on a rising edge where start=1 and ready=1;
    // num is captured on that same edge. start while ready=0 is dropped, not queued.
    // done is a one-cycle pulse, and result holds its value until the next done.
    logic             start;
    logic [IN_W-1:0]  num;
    logic             ready;
    logic             done;
    logic [OUT_W-1:0] result;
`ifdef SQ_ABORT_EN
    logic             abort;
`endif

    modport master (
        output start, num,
`ifdef SQ_ABORT_EN
        output abort,
`endif
        input  ready, done, result
    );

    modport slave (
        input  start, num,
`ifdef SQ_ABORT_EN
        input  abort,
`endif
        output ready, done, result
    );
endinterface

// File: rtl/sq_odd_sum_dp.sv
// Datapath for sq_odd_sum: accumulates consecutive odd numbers into acc.
module sq_odd_sum_dp import sq_pkg::*; #(
    parameter int IN_W  = SQ_IN_W,
    parameter int OUT_W = SQ_OUT_W
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             latch_i,
    input  logic [IN_W-1:0]  num_i,
    output logic             cnt_zero_o,
    output logic [OUT_W-1:0] result_o
);
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [IN_W:0]    odd_q, odd_d;
    logic [IN_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0] result_q, result_d;

    always_comb begin
        acc_d    = acc_q;
        odd_d    = odd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (load_i) begin
            acc_d = '0;
            odd_d = (IN_W+1)'(1);
            cnt_d = num_i;
        end else if (step_i) begin
            // Widths are sized so neither sum can wrap for any num.
            acc_d = acc_q + OUT_W'(odd_q);
            odd_d = odd_q + (IN_W+1)'(2);
            cnt_d = cnt_q - IN_W'(1);
        end
        if (latch_i) begin
            result_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            acc_q    <= '0;
            odd_q    <= (IN_W+1)'(1);
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            odd_q    <= odd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign cnt_zero_o = (cnt_q == '0);
    assign result_o   = result_q;
endmodule

// File: rtl/sq_odd_sum.sv
// Iterative squarer: result = num*num via one odd-number add per clock.
// Optional SQ_ABORT_EN adds an abort input that cancels a running operation.
module sq_odd_sum import sq_pkg::*; #(
    parameter int IN_W  = SQ_IN_W,
    parameter int OUT_W = SQ_OUT_W
) (
    input  logic          clk,
    input  logic          clear_n,
    sq_odd_sum_if.slave   bus,
    output sq_state_t     state_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADD  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q, state_d;
    logic       load, step, latch;
    logic       cnt_zero;
    logic       abort_hit;

`ifdef SQ_ABORT_EN
    assign abort_hit = bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        latch   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                // abort outranks completion so a cancelled op never updates result.
                if (abort_hit) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero) begin
                    latch   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    sq_odd_sum_dp #(.IN_W(IN_W), .OUT_W(OUT_W)) u_dp (
        .clk        (clk),
        .clear_n    (clear_n),
        .load_i     (load),
        .step_i     (step),
        .latch_i    (latch),
        .num_i      (bus.num),
        .cnt_zero_o (cnt_zero),
        .result_o   (bus.result)
    );

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = (state_q == ST_DONE);
    assign state_o   = sq_state_t'(state_q);
endmodule

// File: tb/tb_sq_odd_sum.sv
// Directed + randomized bench for sq_odd_sum against a num*num timing model.
`timescale 1ns/1ps
module tb_sq_odd_sum;
    import sq_pkg::*;

    localparam int IN_W  = 4;
    localparam int OUT_W = 8;

    logic      clk;
    logic      clear_n;
    sq_state_t dbg_state;
    int        n_cmp;
    int        n_bad;
    logic [OUT_W-1:0] last_res;
    logic [OUT_W-1:0] exp_q[$];

    sq_odd_sum_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    sq_odd_sum #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one request at the current negedge and follows it to done.
    task automatic run_op(input int n, input bit hold_start, input int hold_num);
        int   lat;
        bit   stable;
        logic [OUT_W-1:0] expv;
        expv = OUT_W'(n * n);
        exp_q.push_back(expv);
        bus.start = 1'b1;
        bus.num   = IN_W'(n);
        @(posedge clk);
        @(negedge clk);
        if (hold_start) begin
            bus.num = IN_W'(hold_num);
        end else begin
            bus.start = 1'b0;
            bus.num   = IN_W'($urandom_range(0, 15));
        end
        check("busy_ready", 32'(bus.ready), 32'd0);
        lat    = 0;
        stable = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.result !== last_res) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("result_stable_busy", 32'(stable), 32'd1);
        check("done_latency", 32'(lat), 32'(n + 1));
        check("result", 32'(bus.result), 32'(exp_q.pop_front()));
        bus.start = 1'b0;
        last_res  = expv;
        @(negedge clk);
        check("done_one_cycle", 32'(bus.done), 32'd0);
        check("ready_back", 32'(bus.ready), 32'd1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        last_res  = '0;
        clear_n   = 1'b0;
        bus.start = 1'b0;
        bus.num   = '0;
`ifdef SQ_ABORT_EN
        bus.abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        clear_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.ready), 32'd1);
        check("post_rst_state", 32'(dbg_state), 32'(IDLE));

        run_op(5, 1'b0, 0);
        run_op(0, 1'b0, 0);
        run_op(15, 1'b0, 0);

        // Request held high through busy must not start a second op.
        run_op(3, 1'b1, 9);
        repeat (4) begin
            @(negedge clk);
            check("no_second_op_done", 32'(bus.done), 32'd0);
        end
        check("no_second_op_result", 32'(bus.result), 32'd9);

        // Reset in the middle of num=12, asserted just before E0+4.
        bus.start = 1'b1;
        bus.num   = 4'd12;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        clear_n = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        clear_n  = 1'b1;
        last_res = '0;
        @(negedge clk);
        check("midrst_no_done", 32'(bus.done), 32'd0);
        run_op(2, 1'b0, 0);

`ifdef SQ_ABORT_EN
        run_op(5, 1'b0, 0);
        bus.start = 1'b1;
        bus.num   = 4'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_result", 32'(bus.result), 32'd25);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'd0);
        end
`else
        run_op(7, 1'b0, 0);
`endif

        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(int'($urandom_range(0, 15)), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
